// File: rtl/ijvm_pkg.sv
// Shared IJVM datapath types: operand assembler state encoding and operand length codes.
package ijvm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FIRST  = 2'd1,
    SECOND = 2'd2,
    DONE   = 2'd3
  } asm_state_e;

  localparam logic OPLEN_BYTE = 1'b0;
  localparam logic OPLEN_HALF = 1'b1;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;

endpackage : ijvm_pkg

// File: rtl/operand_extend.sv
// Sign/zero extension of an 8- or 16-bit immediate held in a 16-bit accumulator.
module operand_extend
  import ijvm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic [HALF_W-1:0]     acc,
  input  logic                  len,
  input  logic                  is_signed,
  output logic [WORD_WIDTH-1:0] result_c
);

  localparam int unsigned HI_BYTE_W = WORD_WIDTH - BYTE_W;
  localparam int unsigned HI_HALF_W = WORD_WIDTH - HALF_W;

  // Pick the width from len and fill the upper bits with the sign bit or zeros.
  always_comb begin
    result_c = '0;
    if (len == OPLEN_BYTE) begin
      result_c = {{HI_BYTE_W{is_signed & acc[BYTE_W-1]}}, acc[BYTE_W-1:0]};
    end else begin
      result_c = {{HI_HALF_W{is_signed & acc[HALF_W-1]}}, acc};
    end
  end

endmodule : operand_extend

// File: rtl/operand_assembler.sv
// Assembles a big-endian 1- or 2-byte immediate from the instruction byte stream.
module operand_assembler
  import ijvm_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_len,
  input  logic                  req_signed,
  input  logic                  byte_valid,
  input  logic [BYTE_W-1:0]     byte_data,
  output logic                  byte_ready,
  output logic                  op_valid,
  output logic [WORD_WIDTH-1:0] op_data,
  input  logic                  op_ready,
  output logic                  busy
);

  asm_state_e              state_q, state_d;
  logic [HALF_W-1:0]       acc_q, acc_d;
  logic                    len_q, len_d;
  logic                    signed_q, signed_d;
  logic [WORD_WIDTH-1:0]   op_data_q, op_data_d;
  logic [WORD_WIDTH-1:0]   ext_c;

  // Extension is applied to the accumulator value being written, so op_data is ready on DONE entry.
  operand_extend #(.WORD_WIDTH(WORD_WIDTH)) u_extend (
    .acc       (acc_d),
    .len       (len_q),
    .is_signed (signed_q),
    .result_c  (ext_c)
  );

  // Next-state, accumulator and operand register update; flush overrides every handshake.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    len_d     = len_q;
    signed_d  = signed_q;
    op_data_d = op_data_q;
    if (flush) begin
      state_d   = IDLE;
      op_data_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            len_d    = req_len;
            signed_d = req_signed;
            acc_d    = '0;
            state_d  = FIRST;
          end
        end
        FIRST: begin
          if (byte_valid) begin
            acc_d = {acc_q[HALF_W-1:BYTE_W], byte_data};
            if (len_q == OPLEN_BYTE) begin
              state_d   = DONE;
              op_data_d = ext_c;
            end else begin
              state_d = SECOND;
            end
          end
        end
        SECOND: begin
          if (byte_valid) begin
            acc_d     = {acc_q[BYTE_W-1:0], byte_data};
            state_d   = DONE;
            op_data_d = ext_c;
          end
        end
        DONE: begin
          if (op_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      len_q     <= OPLEN_BYTE;
      signed_q  <= 1'b0;
      op_data_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      len_q     <= len_d;
      signed_q  <= signed_d;
      op_data_q <= op_data_d;
    end
  end

  // Handshake flags decode from the registered state only.
  assign req_ready  = (state_q == IDLE);
  assign byte_ready = (state_q == FIRST) || (state_q == SECOND);
  assign op_valid   = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign op_data    = op_data_q;

endmodule : operand_assembler

// File: tb/tb_operand_assembler.sv
// Directed bench for operand_assembler with hand-computed expected operands.
module tb_operand_assembler;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        req_valid, req_ready, req_len, req_signed;
  logic        byte_valid, byte_ready;
  logic [7:0]  byte_data;
  logic        op_valid, op_ready, busy;
  logic [31:0] op_data;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  operand_assembler #(.WORD_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_len    (req_len),
    .req_signed (req_signed),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .op_valid   (op_valid),
    .op_data    (op_data),
    .op_ready   (op_ready),
    .busy       (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Flags packed as {req_ready, byte_ready, op_valid, busy}.
  task automatic check_flags(input string tag, input logic [3:0] exp);
    check(tag, {28'h0, req_ready, byte_ready, op_valid, busy}, {28'h0, exp});
  endtask

  // Back-to-back request, byte(s) and operand handshake.
  task automatic run_op(input string tag, input logic len, input logic sgn,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic [31:0] exp);
    req_valid = 1'b1; req_len = len; req_signed = sgn;
    tick();
    req_valid = 1'b0;
    byte_valid = 1'b1; byte_data = b0;
    tick();
    if (len) begin
      byte_data = b1;
      tick();
    end
    byte_valid = 1'b0;
    check_flags({tag, "_flags"}, 4'b0011);
    check(tag, op_data, exp);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check_flags({tag, "_idle"}, 4'b1000);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_len = 1'b0; req_signed = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00; op_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    check_flags("reset_flags", 4'b1000);
    check("reset_op", op_data, 32'h0);

    // One-byte and two-byte extension cases.
    run_op("b_s80", 1'b0, 1'b1, 8'h80, 8'h00, 32'hFFFFFF80);
    run_op("b_u80", 1'b0, 1'b0, 8'h80, 8'h00, 32'h00000080);
    run_op("b_s7f", 1'b0, 1'b1, 8'h7F, 8'h00, 32'h0000007F);
    run_op("h_sfffe", 1'b1, 1'b1, 8'hFF, 8'hFE, 32'hFFFFFFFE);
    run_op("h_u1234", 1'b1, 1'b0, 8'h12, 8'h34, 32'h00001234);
    run_op("h_s8000", 1'b1, 1'b1, 8'h80, 8'h00, 32'hFFFF8000);
    run_op("h_uff80", 1'b1, 1'b0, 8'hFF, 8'h80, 32'h0000FF80);

    // Stalls on the byte stream and on the operand handshake.
    req_valid = 1'b1; req_len = 1'b1; req_signed = 1'b1;
    tick();
    req_valid = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h7F;
    tick();
    byte_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_flags("stall_byte", 4'b0101);
    end
    byte_valid = 1'b1; byte_data = 8'h01;
    tick();
    byte_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_flags("stall_op_flags", 4'b0011);
      check("stall_op_data", op_data, 32'h00007F01);
      tick();
    end
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check_flags("stall_release", 4'b1000);
    check("stall_op_hold", op_data, 32'h00007F01);

    // Flush after the first byte of a two-byte request.
    req_valid = 1'b1; req_len = 1'b1; req_signed = 1'b1;
    tick();
    req_valid = 1'b0;
    byte_valid = 1'b1; byte_data = 8'hAA;
    tick();
    check_flags("pre_flush", 4'b0101);
    flush = 1'b1; byte_data = 8'h55;
    tick();
    flush = 1'b0; byte_valid = 1'b0;
    check_flags("flush_idle", 4'b1000);
    check("flush_op", op_data, 32'h0);
    tick();
    check_flags("flush_no_op", 4'b1000);
    run_op("post_flush", 1'b0, 1'b0, 8'h05, 8'h00, 32'h00000005);

    // Flush in DONE drops the operand even with op_ready high.
    req_valid = 1'b1; req_len = 1'b0; req_signed = 1'b0;
    tick();
    req_valid = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h3C;
    tick();
    byte_valid = 1'b0;
    check("done_before_flush", op_data, 32'h0000003C);
    flush = 1'b1; op_ready = 1'b1;
    tick();
    flush = 1'b0; op_ready = 1'b0;
    check_flags("flush_done", 4'b1000);
    check("flush_done_op", op_data, 32'h0);

    // Flush in IDLE blocks the request.
    flush = 1'b1; req_valid = 1'b1; req_len = 1'b0;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check_flags("flush_req", 4'b1000);

    // Reset wins over flush and a pending byte in SECOND.
    run_op("pre_rst", 1'b0, 1'b1, 8'hF0, 8'h00, 32'hFFFFFFF0);
    req_valid = 1'b1; req_len = 1'b1; req_signed = 1'b0;
    tick();
    req_valid = 1'b0;
    byte_valid = 1'b1; byte_data = 8'h12;
    tick();
    rst = 1'b1; flush = 1'b1; byte_data = 8'h34;
    tick();
    rst = 1'b0; flush = 1'b0; byte_valid = 1'b0;
    check_flags("rst_flags", 4'b1000);
    check("rst_op", op_data, 32'h0);
    run_op("post_rst", 1'b1, 1'b0, 8'hAB, 8'hCD, 32'h0000ABCD);

    // Request and byte together in IDLE: byte waits for FIRST; requests ignored when busy.
    req_valid = 1'b1; req_len = 1'b0; req_signed = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h11;
    check_flags("both_idle", 4'b1000);
    tick();
    req_len = 1'b1;
    check_flags("both_first", 4'b0101);
    tick();
    req_valid = 1'b0; byte_valid = 1'b0;
    check_flags("both_done", 4'b0011);
    check("both_op", op_data, 32'h00000011);
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check_flags("both_idle_end", 4'b1000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_operand_assembler
